uart_echo: RTL and testbench

Byte-stream responder placed between the UART receiver's output handshake and the UART transmitter's input handshake. It accepts received bytes and buffers them in a FIFO of `DEPTH` entries plus one output holding register. It replays them unchanged to the transmitter, so a host sees every good byte echoed back. Bytes flagged with a framing error are dropped and counted, and receiver overrun events are counted. It is the on-chip far end for the transmitter/receiver pair in loopback bring-up.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_fifo.sv | 54 +++++
 rtl/uart_echo.sv | 133 +++++++++++++
 tb/tb_uart_echo.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART echo block.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } tx_state_t;

  // Increment that sticks at max; callers size-cast the result to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max);
    return (value >= max) ? max : value + 32'd1;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers so full and empty are distinguishable.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == DEPTH_L);
  assign empty    = (wr_ptr == rd_ptr);
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Storage array; contents are meaningless once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update; the extra MSB tells a wrapped-full FIFO from an empty one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/uart_echo.sv
// Echoes good received bytes back to the transmitter through a FIFO and a
// holding register; drops framing-error bytes and counts errors and overruns.
//
// TX output FSM
//   state | meaning
//   EMPTY | holding register empty, tx_valid low
//   FULL  | holding register loaded, tx_valid high, tx_data stable
module uart_echo
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear_counts,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   rx_error,
  input  logic                   rx_overrun,
  output logic                   rx_ready,
  input  logic                   tx_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_WIDTH-1:0]   err_count,
  output logic [CNT_WIDTH-1:0]   ovr_count
);

  localparam logic [31:0] CNT_MAX = (CNT_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << CNT_WIDTH) - 32'd1);

  tx_state_t state_q, state_d;
  byte_t     hold_q;
  byte_t     fifo_head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      accept;
  logic      push;
  logic      pop;
  logic      ovr_s1, ovr_s2;
  logic      ovr_rise;
  logic [CNT_WIDTH-1:0] err_inc;
  logic [CNT_WIDTH-1:0] ovr_inc;

  // Reset is folded in so rx_ready is low for the whole time reset is held.
  assign rx_ready = reset && enable && !fifo_full;
  assign accept   = rx_valid && rx_ready;
  assign push     = accept && !rx_error;
  assign tx_valid = (state_q == FULL);
  assign tx_data  = hold_q;
  assign ovr_rise = ovr_s1 && !ovr_s2;
  assign err_inc  = CNT_WIDTH'(sat_inc(32'(err_count), CNT_MAX));
  assign ovr_inc  = CNT_WIDTH'(sat_inc(32'(ovr_count), CNT_MAX));

  uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (rx_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Next-state and pop decision; fifo_empty is registered, so a byte pushed
  // this edge can never be popped on the same edge.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (!fifo_empty && enable) begin
          pop     = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (tx_ready) begin
          if (!fifo_empty && enable) begin
            pop = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // FSM state and holding register, loaded from the FIFO head on each pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      hold_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (pop) hold_q <= fifo_head;
    end
  end

  // Overrun edge detector; the previous sample starts at 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovr_s1 <= 1'b0;
      ovr_s2 <= 1'b0;
    end else begin
      ovr_s1 <= rx_overrun;
      ovr_s2 <= ovr_s1;
    end
  end

  // Saturating counters; clear takes priority over a same-edge increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
      ovr_count <= '0;
    end else if (clear_counts) begin
      err_count <= '0;
      ovr_count <= '0;
    end else begin
      if (accept && rx_error) err_count <= err_inc;
      if (ovr_rise)           ovr_count <= ovr_inc;
    end
  end

endmodule

// File: tb/tb_uart_echo.sv
// Directed testbench for uart_echo with DEPTH=16, CNT_WIDTH=8.
module tb_uart_echo;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear_counts;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;
  logic       rx_overrun;
  logic       rx_ready;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [4:0] level;
  logic [7:0] err_count;
  logic [7:0] ovr_count;

  int checks   = 0;
  int failures = 0;

  uart_echo #(.DEPTH(16), .CNT_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear_counts (clear_counts),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_error     (rx_error),
    .rx_overrun   (rx_overrun),
    .rx_ready     (rx_ready),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .level        (level),
    .err_count    (err_count),
    .ovr_count    (ovr_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; clear_counts = 1'b0; rx_valid = 1'b0;
    rx_data = 8'h00; rx_error = 1'b0; rx_overrun = 1'b0; tx_ready = 1'b1;
    ticks(3);
    checks++;
    if (rx_ready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready got=%0b exp=0", rx_ready); end
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      failures++; $display("FAIL reset_tx got valid=%0b data=%h exp valid=0 data=00", tx_valid, tx_data);
    end
    checks++;
    if (level !== 5'd0 || err_count !== 8'd0 || ovr_count !== 8'd0) begin
      failures++; $display("FAIL reset_regs got level=%0d err=%0d ovr=%0d exp 0 0 0", level, err_count, ovr_count);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (rx_ready !== 1'b1) begin failures++; $display("FAIL post_reset_rx_ready got=%0b exp=1", rx_ready); end
  endtask

  task automatic test_single_echo();
    tx_ready = 1'b1;
    rx_valid = 1'b1; rx_data = 8'hA5;
    tick();
    rx_valid = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || level !== 5'd1) begin
      failures++; $display("FAIL echo_edge_n got valid=%0b level=%0d exp valid=0 level=1", tx_valid, level);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || level !== 5'd0) begin
      failures++; $display("FAIL echo_edge_n1 got valid=%0b data=%h level=%0d exp 1 a5 0", tx_valid, tx_data, level);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL echo_one_beat got valid=%0b exp=0", tx_valid); end
  endtask

  task automatic test_backpressure_fill();
    int accepted;
    accepted = 0;
    tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      rx_valid = 1'b1; rx_data = 8'(i);
      if (rx_ready) accepted++;
      tick();
    end
    rx_valid = 1'b0;
    checks++;
    if (accepted != 17) begin failures++; $display("FAIL fill_accepted got=%0d exp=17", accepted); end
    checks++;
    if (rx_ready !== 1'b0 || level !== 5'd16) begin
      failures++; $display("FAIL fill_full got rx_ready=%0b level=%0d exp 0 16", rx_ready, level);
    end
    tx_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(k)) begin
        failures++; $display("FAIL drain_beat_%0d got valid=%0b data=%h exp valid=1 data=%h", k, tx_valid, tx_data, 8'(k));
      end
      tick();
    end
    checks++;
    if (tx_valid !== 1'b0 || level !== 5'd0) begin
      failures++; $display("FAIL drain_done got valid=%0b level=%0d exp 0 0", tx_valid, level);
    end
  endtask

  task automatic test_error_drop();
    logic [7:0] seen [4];
    int         n_seen;
    n_seen = 0;
    tx_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rx_valid = (c < 3);
      rx_data  = (c == 0) ? 8'h11 : (c == 1) ? 8'h22 : 8'h33;
      rx_error = (c == 1);
      if (tx_valid && n_seen < 4) begin
        seen[n_seen] = tx_data;
        n_seen++;
      end
      tick();
    end
    rx_valid = 1'b0; rx_error = 1'b0;
    checks++;
    if (n_seen != 2) begin
      failures++; $display("FAIL err_drop_count got=%0d exp=2", n_seen);
    end else begin
      checks++;
      if (seen[0] !== 8'h11 || seen[1] !== 8'h33) begin
        failures++; $display("FAIL err_drop_data got=%h,%h exp=11,33", seen[0], seen[1]);
      end
    end
    checks++;
    if (err_count !== 8'd1) begin failures++; $display("FAIL err_count got=%0d exp=1", err_count); end
  endtask

  task automatic test_overrun();
    rx_overrun = 1'b1;
    ticks(5);
    rx_overrun = 1'b0;
    ticks(3);
    checks++;
    if (ovr_count !== 8'd1) begin failures++; $display("FAIL ovr_held got=%0d exp=1", ovr_count); end
    for (int p = 0; p < 300; p++) begin
      rx_overrun = 1'b1; tick();
      rx_overrun = 1'b0; tick();
    end
    ticks(3);
    checks++;
    if (ovr_count !== 8'hFF) begin failures++; $display("FAIL ovr_saturate got=%h exp=ff", ovr_count); end
    rx_overrun = 1'b1; clear_counts = 1'b1;
    tick();
    rx_overrun = 1'b0;
    tick();
    clear_counts = 1'b0;
    ticks(3);
    checks++;
    if (ovr_count !== 8'd0 || err_count !== 8'd0) begin
      failures++; $display("FAIL clear_wins got ovr=%0d err=%0d exp 0 0", ovr_count, err_count);
    end
  endtask

  task automatic test_enable_low();
    logic [7:0] seen [4];
    int         n_seen;
    n_seen = 0;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1; rx_data = 8'h40 + 8'(i);
      tick();
    end
    rx_valid = 1'b0;
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h40 || level !== 5'd3) begin
      failures++; $display("FAIL en_setup got valid=%0b data=%h level=%0d exp 1 40 3", tx_valid, tx_data, level);
    end
    enable = 1'b0; tx_ready = 1'b1;
    rx_valid = 1'b1; rx_data = 8'hEE;
    tick();
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b0 || level !== 5'd3) begin
      failures++; $display("FAIL en_low_complete got valid=%0b rx_ready=%0b level=%0d exp 0 0 3", tx_valid, rx_ready, level);
    end
    ticks(3);
    rx_valid = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || level !== 5'd3) begin
      failures++; $display("FAIL en_low_hold got valid=%0b level=%0d exp 0 3", tx_valid, level);
    end
    enable = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (tx_valid && n_seen < 4) begin
        seen[n_seen] = tx_data;
        n_seen++;
      end
      tick();
    end
    checks++;
    if (n_seen != 3) begin
      failures++; $display("FAIL en_resume_count got=%0d exp=3", n_seen);
    end else begin
      checks++;
      if (seen[0] !== 8'h41 || seen[1] !== 8'h42 || seen[2] !== 8'h43) begin
        failures++; $display("FAIL en_resume_data got=%h,%h,%h exp=41,42,43", seen[0], seen[1], seen[2]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] seen [4];
    int         n_seen;
    n_seen = 0;
    tx_ready = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h99; rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    rx_overrun = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_data = 8'h50 + 8'(i);
      tick();
      rx_overrun = 1'b0;
    end
    rx_valid = 1'b0;
    ticks(2);
    checks++;
    if (level !== 5'd5 || tx_valid !== 1'b1 || err_count !== 8'd1 || ovr_count !== 8'd1) begin
      failures++; $display("FAIL arst_setup got level=%0d valid=%0b err=%0d ovr=%0d exp 5 1 1 1", level, tx_valid, err_count, ovr_count);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || level !== 5'd0 || err_count !== 8'd0 || ovr_count !== 8'd0) begin
      failures++; $display("FAIL arst_async got valid=%0b level=%0d err=%0d ovr=%0d exp 0 0 0 0", tx_valid, level, err_count, ovr_count);
    end
    #2 reset = 1'b1;
    tick();
    tx_ready = 1'b1;
    ticks(4);
    checks++;
    if (tx_valid !== 1'b0 || level !== 5'd0) begin
      failures++; $display("FAIL arst_no_stale got valid=%0b level=%0d exp 0 0", tx_valid, level);
    end
    rx_valid = 1'b1; rx_data = 8'h77;
    for (int c = 0; c < 6; c++) begin
      if (tx_valid && n_seen < 4) begin
        seen[n_seen] = tx_data;
        n_seen++;
      end
      tick();
      rx_valid = 1'b0;
    end
    checks++;
    if (n_seen != 1 || seen[0] !== 8'h77) begin
      failures++; $display("FAIL arst_fresh got count=%0d first=%h exp 1 77", n_seen, seen[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_echo();
    test_backpressure_fill();
    test_error_drop();
    test_overrun();
    test_enable_low();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
